weight_readout: RTL and testbench

//  Reads the thermometer-coded synaptic weights produced by the STDP learning

---
 rtl/weight_readout.sv | 139 +++++++++++++
 tb/tb_weight_readout.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_readout.sv
// Streams a snapshot of the thermometer-coded STDP weights out as binary counts,
// one synapse per valid/ready handshake, in neuron-major order.
module weight_readout #(
    parameter  int NEURONS  = 2,
    parameter  int SYNAPSES = 4,
    parameter  int PERIOD   = 8,
    localparam int WW       = $clog2(PERIOD + 1),
    localparam int NW       = $clog2(NEURONS),
    localparam int SW       = $clog2(SYNAPSES)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NEURONS-1:0][SYNAPSES-1:0][PERIOD-1:0] weights,
    input  logic                                         start,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic                                         out_valid,
    output logic [WW-1:0]                                out_data,
    output logic [NW-1:0]                                out_neuron,
    output logic [SW-1:0]                                out_synapse,
    output logic                                         out_last,
    output logic                                         done,
    output logic                                         code_err
);

    // state  | meaning
    // IDLE   | waiting for start; weights not sampled
    // STREAM | presenting snapshot[n][s]; advance on handshake
    // DONE   | one-cycle done pulse after the final handshake
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                                       state_q, state_d;
    logic [NEURONS-1:0][SYNAPSES-1:0][PERIOD-1:0] snap_q,  snap_d;
    logic [NW-1:0]                                n_q,     n_d;
    logic [SW-1:0]                                s_q,     s_d;
    logic                                         err_q,   err_d;

    logic [PERIOD-1:0] cur_code;
    logic              at_last;
    logic              streaming;

    function automatic logic [WW-1:0] popcount(input logic [PERIOD-1:0] c);
        logic [WW-1:0] acc;
        acc = '0;
        for (int i = 0; i < PERIOD; i++) begin
            acc = acc + WW'(c[i]);
        end
        return acc;
    endfunction

    // A legal code never has a set bit below a clear bit (ones packed at the MSB end).
    function automatic logic is_thermo(input logic [PERIOD-1:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PERIOD - 1; i++) begin
            if (c[i] && !c[i+1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign cur_code  = snap_q[n_q][s_q];
    assign streaming = (state_q == STREAM);
    assign at_last   = (n_q == NW'(NEURONS - 1)) && (s_q == SW'(SYNAPSES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            n_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            n_q     <= n_d;
            s_q     <= s_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        n_d     = n_q;
        s_d     = s_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = weights;
                    err_d   = 1'b0;
                    n_d     = '0;
                    s_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (!is_thermo(cur_code)) begin
                        err_d = 1'b1;
                    end
                    if (at_last) begin
                        n_d     = '0;
                        s_d     = '0;
                        state_d = DONE;
                    end else if (s_q == SW'(SYNAPSES - 1)) begin
                        s_d = '0;
                        n_d = n_q + NW'(1);
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data fields are forced to zero outside STREAM so the bus is quiet when idle.
    assign busy        = (state_q != IDLE);
    assign out_valid   = streaming;
    assign out_data    = streaming ? popcount(cur_code) : '0;
    assign out_neuron  = streaming ? n_q : '0;
    assign out_synapse = streaming ? s_q : '0;
    assign out_last    = streaming && at_last;
    assign done        = (state_q == DONE);
    assign code_err    = err_q;

endmodule

// File: tb/tb_weight_readout.sv
// Scoreboard bench for weight_readout: directed dumps push expected words,
// a negedge monitor pops and compares on every presented word.
module tb_weight_readout;

    logic                        clk;
    logic                        rst_n;
    logic [1:0][3:0][7:0]        weights;
    logic                        start;
    logic                        out_ready;
    logic                        busy;
    logic                        out_valid;
    logic [3:0]                  out_data;
    logic [0:0]                  out_neuron;
    logic [1:0]                  out_synapse;
    logic                        out_last;
    logic                        done;
    logic                        code_err;

    weight_readout #(.NEURONS(2), .SYNAPSES(4), .PERIOD(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .weights     (weights),
        .start       (start),
        .out_ready   (out_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_neuron  (out_neuron),
        .out_synapse (out_synapse),
        .out_last    (out_last),
        .done        (done),
        .code_err    (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       n;
        logic [1:0] s;
        logic       last;
        logic       bad;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic sb_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a word is presented it must match the queue head
    // (so a stalled word must stay identical); pop only on handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 32'd1, 32'd0);
            end else begin
                chk("data",     32'(out_data),    32'(q[0].data));
                chk("neuron",   32'(out_neuron),  32'(q[0].n));
                chk("synapse",  32'(out_synapse), 32'(q[0].s));
                chk("last",     32'(out_last),    32'(q[0].last));
                chk("code_err", 32'(code_err),    32'(sb_err));
                chk("done_in_stream", 32'(done),  32'd0);
                if (out_ready) begin
                    if (q[0].bad) sb_err = 1'b1;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic set_all(input logic [7:0] c);
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < 4; s++)
                weights[n][s] = c;
    endtask

    // Ramp pattern: word i holds i+1 ones.
    task automatic set_ramp();
        logic [7:0] ff;
        ff = 8'hFF;
        for (int i = 0; i < 8; i++) weights[i/4][i%4] = ff << (7 - i);
    endtask

    // exp_words: nibble i = expected data of word i; bad: bit i = word i illegal.
    task automatic run_dump(input string tag, input logic [31:0] exp_words, input logic [7:0] bad,
                            input logic [3:0] rpat, input bit mid_ops, input bit abort3,
                            input logic exp_err);
        int cyc;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = exp_words[4*i +: 4];
            e.n    = 1'(i / 4);
            e.s    = 2'(i % 4);
            e.last = (i == 7);
            e.bad  = bad[i];
            q.push_back(e);
        end
        sb_err    = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_prestart_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_err_cleared"}, 32'(code_err), 32'd0);
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            out_ready = rpat[cyc % 4];
            if (mid_ops && cyc == 0) set_all(8'hFE);
            if (mid_ops && cyc == 3) start = 1'b1;
            if (mid_ops && cyc == 4) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (mid_ops && q.size() != 0) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
            if (abort3 && q.size() == 5) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_abort_outputs"},
                    32'({busy, out_valid, out_data, out_neuron, out_synapse, out_last, done, code_err}),
                    32'd0);
                q.delete();
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, "_abort_no_done"}, 32'(done), 32'd0);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, "_post_abort_done"}, 32'(done), 32'd0);
                    chk({tag, "_post_abort_busy"}, 32'(busy), 32'd0);
                end
                @(posedge clk); #1;
                return;
            end
        end
        if (q.size() != 0) begin
            chk({tag, "_timeout_words_left"}, 32'(q.size()), 32'd0);
            q.delete();
        end
        out_ready = 1'b1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done_err"}, 32'(code_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_after_done"}, 32'(done), 32'd0);
        chk({tag, "_after_busy"}, 32'(busy), 32'd0);
        chk({tag, "_after_err"}, 32'(code_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_no_restart"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        weights   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({busy, out_valid, out_data, out_neuron, out_synapse, out_last, done, code_err}),
            32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_all(8'hF0);
        run_dump("t1", 32'h44444444, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0);

        set_all(8'hC0);
        weights[1][2] = 8'hFF;
        weights[0][1] = 8'h00;
        run_dump("t2", 32'h28222202, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0);

        set_ramp();
        run_dump("t3", 32'h87654321, 8'h00, 4'b1001, 1'b0, 1'b0, 1'b0);

        set_ramp();
        run_dump("t4", 32'h87654321, 8'h00, 4'b1111, 1'b1, 1'b0, 1'b0);

        set_all(8'hF0);
        weights[0][3] = 8'hA0;
        run_dump("t5", 32'h44442444, 8'h08, 4'b1111, 1'b0, 1'b0, 1'b1);

        set_all(8'hF0);
        run_dump("t6a", 32'h44444444, 8'h00, 4'b1111, 1'b0, 1'b1, 1'b0);
        run_dump("t6b", 32'h44444444, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
